wr_burst_fifo_mc: RTL and testbench

- Multi-channel, single-clock successor to the write burst FIFO.
- NCH independent upstream write streams, each buffered in its own FWFT FIFO.
- A round-robin burst scheduler issues one memory-write burst request at a time, then streams that channel's words to the memory write path.
- Adds per-channel flush (partial burst), burst length reporting, rd_last framing and clearable sticky overflow errors.

---
 rtl/wr_burst_fifo_mc.sv | 195 +++++++++++++++++++
 tb/tb_wr_burst_fifo_mc.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_burst_fifo_mc.sv
// Multi-channel write burst FIFO. Each upstream channel fills its own FWFT
// buffer; a round-robin scheduler picks one channel at a time, requests a
// memory-write burst for it and then streams that channel's words out.
//
// Handshake semantics: a transfer happens on a rising clk edge exactly when
// valid and ready are both high in that cycle (wr_vld_i/wr_rdy_o per channel,
// rd_vld_o/rd_rdy_i on the read side). Valid never depends combinationally on
// ready. burst_req_o is held with stable burst_ch_o/burst_len_o until the
// one-cycle burst_gnt_i pulse is seen.
module wr_burst_fifo_mc #(
    parameter int DSIZE     = 36,
    parameter int DEPTH     = 512,
    parameter int NCH       = 2,
    parameter int BURST_LEN = 16,
    parameter int AW        = $clog2(DEPTH),
    parameter int CW        = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int LW        = $clog2(BURST_LEN) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          wr_vld_i,
    output logic [NCH-1:0]          wr_rdy_o,
    input  logic [NCH*DSIZE-1:0]    wr_data_i,
    input  logic [NCH-1:0]          flush_i,
    output logic                    burst_req_o,
    output logic [CW-1:0]           burst_ch_o,
    output logic [LW-1:0]           burst_len_o,
    input  logic                    burst_gnt_i,
    output logic                    rd_vld_o,
    input  logic                    rd_rdy_i,
    output logic [DSIZE-1:0]        rd_data_o,
    output logic                    rd_last_o,
    output logic [NCH*(AW+1)-1:0]   level_o,
    output logic [NCH-1:0]          err_full_o,
    input  logic                    err_clr_i
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   BL_CNT   = (AW+1)'(BURST_LEN);
    localparam logic [LW-1:0] BL_LEN   = LW'(BURST_LEN);

    // Scheduler state; state_q is the observable FSM state.
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} state_t;
    state_t state_q, state_d;

    logic [DSIZE-1:0] mem [NCH][DEPTH];
    logic [AW-1:0]    wptr_q  [NCH];
    logic [AW-1:0]    rptr_q  [NCH];
    logic [AW:0]      count_q [NCH];
    logic [NCH-1:0]   flush_pend_q;
    logic [NCH-1:0]   err_q;

    logic [CW-1:0]    rr_q, ch_q, ch_d;
    logic [LW-1:0]    len_q, len_d, rem_q;
    logic [AW:0]      cnt_sel;

    logic [NCH-1:0]   wr_fire, ovf, pop, elig, pend_clr;
    logic             launch, rd_fire, found;

    assign rd_fire = rd_vld_o & rd_rdy_i;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign wr_rdy_o[c] = (count_q[c] != FULL_CNT);
        assign wr_fire[c]  = wr_vld_i[c] & wr_rdy_o[c];
        assign ovf[c]      = wr_vld_i[c] & ~wr_rdy_o[c];
        assign pop[c]      = rd_fire & (ch_q == CW'(c));
        assign elig[c]     = (count_q[c] >= BL_CNT) |
                             (flush_pend_q[c] & (count_q[c] != '0));
        // Flush is satisfied only when the launched burst takes every word.
        assign pend_clr[c] = launch & (ch_d == CW'(c)) &
                             ((AW+1)'(len_d) == count_q[c]);
        assign level_o[c*(AW+1) +: AW+1] = count_q[c];
    end

    // Round-robin pick: first eligible channel after the last one served.
    always_comb begin
        int idx;
        logic [CW-1:0] cand;
        idx   = 0;
        cand  = '0;
        found = 1'b0;
        ch_d  = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NCH) idx = idx - NCH;
            cand = CW'(idx);
            if (!found && elig[cand]) begin
                found = 1'b1;
                ch_d  = cand;
            end
        end
        cnt_sel = count_q[ch_d];
        len_d   = (cnt_sel >= BL_CNT) ? BL_LEN : cnt_sel[LW-1:0];
    end

    // FSM next state: IDLE picks, REQ waits for grant, XFER streams words.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    launch  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (burst_gnt_i) state_d = ST_XFER;
            end
            ST_XFER: begin
                if (rd_fire && rem_q == LW'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Burst bookkeeping: latched channel/length, remaining beats, rr pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q  <= '0;
            len_q <= '0;
            rem_q <= '0;
            rr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        ch_q  <= ch_d;
                        len_q <= len_d;
                    end
                end
                ST_REQ: begin
                    if (burst_gnt_i) rem_q <= len_q;
                end
                ST_XFER: begin
                    if (rd_fire) begin
                        rem_q <= rem_q - LW'(1);
                        if (rem_q == LW'(1)) rr_q <= ch_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-channel pointers, counts, flush-pending and sticky overflow bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                wptr_q[c]  <= '0;
                rptr_q[c]  <= '0;
                count_q[c] <= '0;
            end
            flush_pend_q <= '0;
            err_q        <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (wr_fire[c]) wptr_q[c] <= wptr_q[c] + AW'(1);
                if (pop[c])     rptr_q[c] <= rptr_q[c] + AW'(1);
                case ({wr_fire[c], pop[c]})
                    2'b10:   count_q[c] <= count_q[c] + (AW+1)'(1);
                    2'b01:   count_q[c] <= count_q[c] - (AW+1)'(1);
                    default: ;
                endcase
                if (pend_clr[c])
                    flush_pend_q[c] <= flush_i[c] & wr_fire[c];
                else if (flush_i[c] & ((count_q[c] != '0) | wr_fire[c]))
                    flush_pend_q[c] <= 1'b1;
                err_q[c] <= ovf[c] | (err_q[c] & ~err_clr_i);
            end
        end
    end

    // Buffer storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (wr_fire[c]) mem[c][wptr_q[c]] <= wr_data_i[c*DSIZE +: DSIZE];
        end
    end

    assign burst_req_o = (state_q == ST_REQ);
    assign burst_ch_o  = ch_q;
    assign burst_len_o = len_q;
    assign rd_vld_o    = (state_q == ST_XFER) && (rem_q != '0);
    assign rd_last_o   = rd_vld_o && (rem_q == LW'(1));
    assign rd_data_o   = mem[ch_q][rptr_q[ch_q]];
    assign err_full_o  = err_q;

endmodule

// File: tb/tb_wr_burst_fifo_mc.sv
// Bench for wr_burst_fifo_mc: transaction-level reference model with
// per-channel expected-data queues, randomized traffic and directed scenarios.
module tb_wr_burst_fifo_mc;

    localparam int DSIZE = 36;
    localparam int DEPTH = 512;
    localparam int NCH   = 2;
    localparam int BL    = 16;
    localparam int AW    = 9;
    localparam int CW    = 1;
    localparam int LW    = 5;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NCH-1:0]        wr_vld_i;
    logic [NCH-1:0]        wr_rdy_o;
    logic [NCH*DSIZE-1:0]  wr_data_i;
    logic [NCH-1:0]        flush_i;
    logic                  burst_req_o;
    logic [CW-1:0]         burst_ch_o;
    logic [LW-1:0]         burst_len_o;
    logic                  burst_gnt_i;
    logic                  rd_vld_o;
    logic                  rd_rdy_i;
    logic [DSIZE-1:0]      rd_data_o;
    logic                  rd_last_o;
    logic [NCH*(AW+1)-1:0] level_o;
    logic [NCH-1:0]        err_full_o;
    logic                  err_clr_i;

    wr_burst_fifo_mc #(.DSIZE(DSIZE), .DEPTH(DEPTH), .NCH(NCH), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_vld_i(wr_vld_i), .wr_rdy_o(wr_rdy_o), .wr_data_i(wr_data_i),
        .flush_i(flush_i),
        .burst_req_o(burst_req_o), .burst_ch_o(burst_ch_o), .burst_len_o(burst_len_o),
        .burst_gnt_i(burst_gnt_i),
        .rd_vld_o(rd_vld_o), .rd_rdy_i(rd_rdy_i), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
        .level_o(level_o), .err_full_o(err_full_o), .err_clr_i(err_clr_i)
    );

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [DSIZE-1:0] exp_q [NCH][$];
    bit m_pend [NCH];
    bit m_err  [NCH];
    int m_rr, m_ch, m_len, m_rem;
    bit m_req, m_act;
    int done_cnt = 0;
    int log_ch[$];
    int log_len[$];
    logic [DSIZE-1:0] last_data;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            exp_q[c].delete();
            m_pend[c] = 0;
            m_err[c]  = 0;
        end
        m_rr = 0; m_ch = 0; m_len = 0; m_rem = 0;
        m_req = 0; m_act = 0;
    endtask

    task automatic clear_inputs();
        wr_vld_i    = '0;
        flush_i     = '0;
        burst_gnt_i = 1'b0;
        err_clr_i   = 1'b0;
    endtask

    function automatic bit all_empty();
        bit e = 1;
        for (int c = 0; c < NCH; c++) if (exp_q[c].size() != 0) e = 0;
        return e;
    endfunction

    // Scoreboard step: inputs are already driven at the negedge; apply this
    // cycle to the model, advance one clock and compare at the next negedge.
    task automatic clk_step();
        int  s_size [NCH];
        bit  s_pend [NCH];
        int  s_rr, sel, slen;
        bit  fire, ovf, found, exp_v, just_done;
        for (int c = 0; c < NCH; c++) begin
            s_size[c] = exp_q[c].size();
            s_pend[c] = m_pend[c];
        end
        s_rr = m_rr;
        just_done = 0;

        exp_v = m_act && (m_rem != 0);
        total++;
        if (rd_vld_o !== exp_v) begin
            bad++; $display("FAIL rd_vld: got %b expected %b", rd_vld_o, exp_v);
        end
        total++;
        if (rd_last_o !== (exp_v && m_rem == 1)) begin
            bad++; $display("FAIL rd_last: got %b expected %b (remaining %0d)", rd_last_o, exp_v && m_rem == 1, m_rem);
        end
        if (exp_v) begin
            total++;
            if (rd_data_o !== exp_q[m_ch][0]) begin
                bad++; $display("FAIL rd_data: ch %0d got %0h expected %0h", m_ch, rd_data_o, exp_q[m_ch][0]);
            end
            if (rd_rdy_i) begin
                if (m_rem == 1) last_data = rd_data_o;
                void'(exp_q[m_ch].pop_front());
                m_rem--;
                if (m_rem == 0) begin
                    m_act = 0; m_rr = m_ch; done_cnt++; just_done = 1;
                end
            end
        end

        for (int c = 0; c < NCH; c++) begin
            fire = wr_vld_i[c] && (s_size[c] < DEPTH);
            ovf  = wr_vld_i[c] && !fire;
            if (fire) exp_q[c].push_back(wr_data_i[c*DSIZE +: DSIZE]);
            if (flush_i[c] && (s_size[c] != 0 || fire)) m_pend[c] = 1;
            m_err[c] = ovf || (m_err[c] && !err_clr_i);
        end

        if (burst_gnt_i && m_req) begin
            m_req = 0; m_act = 1; m_rem = m_len;
        end

        @(posedge clk);
        @(negedge clk);

        if (burst_req_o && !m_req) begin
            found = 0; sel = 0; slen = 0;
            for (int i = 1; i <= NCH; i++) begin
                int cc;
                cc = (s_rr + i) % NCH;
                if (!found && (s_size[cc] >= BL || (s_pend[cc] && s_size[cc] != 0))) begin
                    found = 1; sel = cc; slen = (s_size[cc] < BL) ? s_size[cc] : BL;
                end
            end
            total++;
            if (!found || m_act || just_done) begin
                bad++; $display("FAIL req_spurious: got req=1 expected req=0 (eligible=%0d active=%0d)", found, m_act);
            end else begin
                m_req = 1; m_ch = sel; m_len = slen;
                if (slen == s_size[sel]) m_pend[sel] = 0;
                log_ch.push_back(int'(burst_ch_o));
                log_len.push_back(int'(burst_len_o));
            end
        end
        if (m_req) begin
            total++;
            if (burst_req_o !== 1'b1) begin
                bad++; $display("FAIL req_held: got %b expected 1", burst_req_o);
            end
            total++;
            if (burst_ch_o !== CW'(m_ch)) begin
                bad++; $display("FAIL burst_ch: got %0d expected %0d", burst_ch_o, m_ch);
            end
            total++;
            if (burst_len_o !== LW'(m_len)) begin
                bad++; $display("FAIL burst_len: got %0d expected %0d", burst_len_o, m_len);
            end
        end
        for (int c = 0; c < NCH; c++) begin
            total++;
            if (level_o[c*(AW+1) +: AW+1] !== (AW+1)'(exp_q[c].size())) begin
                bad++; $display("FAIL level[%0d]: got %0d expected %0d", c, level_o[c*(AW+1) +: AW+1], exp_q[c].size());
            end
            total++;
            if (wr_rdy_o[c] !== (exp_q[c].size() != DEPTH)) begin
                bad++; $display("FAIL wr_rdy[%0d]: got %b expected %b", c, wr_rdy_o[c], exp_q[c].size() != DEPTH);
            end
            total++;
            if (err_full_o[c] !== m_err[c]) begin
                bad++; $display("FAIL err_full[%0d]: got %b expected %b", c, err_full_o[c], m_err[c]);
            end
        end
    endtask

    // Driver tasks
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        model_reset();
        log_ch.delete();
        log_len.delete();
        rst_n = 1'b1;
    endtask

    task automatic write_words(input bit [NCH-1:0] mask, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < NCH; c++) begin
                wr_vld_i[c] = mask[c];
                wr_data_i[c*DSIZE +: DSIZE] = DSIZE'(base + c * 256 + i);
            end
            clk_step();
        end
        wr_vld_i = '0;
    endtask

    task automatic pulse_flush(input bit [NCH-1:0] mask);
        flush_i = mask;
        clk_step();
        flush_i = '0;
    endtask

    task automatic run_bursts(input int target, input int gnt_dly, input int rdy_pct,
                              input bit [NCH-1:0] wr_mask, input int budget);
        int start, cyc, rq;
        start = done_cnt; cyc = 0; rq = 0;
        while ((done_cnt - start) < target && cyc < budget) begin
            for (int c = 0; c < NCH; c++) begin
                wr_vld_i[c] = wr_mask[c] && ($urandom_range(1, 0) == 1);
                wr_data_i[c*DSIZE +: DSIZE] = {4'($urandom_range(15, 0)), 32'($urandom)};
            end
            rd_rdy_i = ($urandom_range(99, 0) < rdy_pct);
            burst_gnt_i = 1'b0;
            if (burst_req_o) begin
                if (rq >= gnt_dly) begin burst_gnt_i = 1'b1; rq = 0; end
                else rq++;
            end
            clk_step();
            cyc++;
        end
        clear_inputs();
        total++;
        if ((done_cnt - start) < target) begin
            bad++; $display("FAIL run_timeout: got %0d bursts expected %0d", done_cnt - start, target);
        end
    endtask

    task automatic drain_all(input int budget);
        int k, rq;
        k = 0; rq = 0;
        for (int c = 0; c < NCH; c++) flush_i[c] = (exp_q[c].size() != 0);
        while (k < budget && !(all_empty() && !m_req && !m_act)) begin
            rd_rdy_i = ($urandom_range(99, 0) < 70);
            burst_gnt_i = 1'b0;
            if (burst_req_o) begin
                if (rq >= 1) begin burst_gnt_i = 1'b1; rq = 0; end
                else rq++;
            end
            clk_step();
            flush_i = '0;
            k++;
        end
        clear_inputs();
        total++;
        if (!(all_empty() && !m_req && !m_act)) begin
            bad++; $display("FAIL drain_timeout: got busy expected drained");
        end
    endtask

    // Scenarios
    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (wr_rdy_o !== '1)      begin bad++; $display("FAIL rst_wr_rdy: got %b expected 11", wr_rdy_o); end
        total++; if (burst_req_o !== 1'b0) begin bad++; $display("FAIL rst_req: got %b expected 0", burst_req_o); end
        total++; if (rd_vld_o !== 1'b0)    begin bad++; $display("FAIL rst_rd_vld: got %b expected 0", rd_vld_o); end
        total++; if (rd_last_o !== 1'b0)   begin bad++; $display("FAIL rst_rd_last: got %b expected 0", rd_last_o); end
        total++; if (burst_ch_o !== '0)    begin bad++; $display("FAIL rst_ch: got %0d expected 0", burst_ch_o); end
        total++; if (burst_len_o !== '0)   begin bad++; $display("FAIL rst_len: got %0d expected 0", burst_len_o); end
        total++; if (level_o !== '0)       begin bad++; $display("FAIL rst_level: got %0h expected 0", level_o); end
        total++; if (err_full_o !== '0)    begin bad++; $display("FAIL rst_err: got %b expected 0", err_full_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_burst();
        rd_rdy_i = 1'b1;
        write_words(2'b01, 16, 0);
        run_bursts(1, 1, 100, 2'b00, 200);
        total++;
        if (log_ch.size() != 1 || log_ch[0] != 0 || log_len[0] != 16) begin
            bad++; $display("FAIL single_burst: got %0d bursts ch=%0d len=%0d expected 1 ch=0 len=16",
                            log_ch.size(), log_ch.size() ? log_ch[0] : -1, log_len.size() ? log_len[0] : -1);
        end
        total++;
        if (last_data !== 36'h00F) begin
            bad++; $display("FAIL single_last_word: got %0h expected f", last_data);
        end
        total++;
        if (level_o[AW:0] !== '0) begin
            bad++; $display("FAIL single_level: got %0d expected 0", level_o[AW:0]);
        end
    endtask

    task automatic test_two_channel_rr();
        apply_reset();
        rd_rdy_i = 1'b1;
        write_words(2'b11, 32, 'h1000);
        run_bursts(4, 1, 100, 2'b00, 400);
        total++;
        if (log_ch.size() != 4) begin
            bad++; $display("FAIL rr_count: got %0d expected 4", log_ch.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (log_ch[i] != ((i % 2 == 0) ? 1 : 0) || log_len[i] != 16) begin
                    bad++; $display("FAIL rr_order[%0d]: got ch=%0d len=%0d expected ch=%0d len=16",
                                    i, log_ch[i], log_len[i], (i % 2 == 0) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_flush();
        bit saw;
        apply_reset();
        rd_rdy_i = 1'b1;
        write_words(2'b10, 5, 'h2000);
        pulse_flush(2'b10);
        run_bursts(1, 0, 100, 2'b00, 100);
        total++;
        if (log_ch.size() != 1 || log_ch[0] != 1 || log_len[0] != 5) begin
            bad++; $display("FAIL flush_burst: got %0d bursts expected 1 burst ch=1 len=5", log_ch.size());
        end
        // Flush on an empty channel must not arm a request.
        pulse_flush(2'b10);
        saw = 0;
        repeat (10) begin clk_step(); if (burst_req_o) saw = 1; end
        write_words(2'b10, 3, 'h2100);
        repeat (10) begin clk_step(); if (burst_req_o) saw = 1; end
        total++;
        if (saw) begin
            bad++; $display("FAIL flush_empty: got req=1 expected req=0");
        end
        pulse_flush(2'b10);
        run_bursts(1, 2, 100, 2'b00, 100);
        total++;
        if (log_len.size() != 2 || log_len[1] != 3) begin
            bad++; $display("FAIL flush_second: got %0d bursts expected second len=3", log_len.size());
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        rd_rdy_i = 1'b1;
        write_words(2'b01, DEPTH, 'h3000);
        total++;
        if (wr_rdy_o[0] !== 1'b0) begin bad++; $display("FAIL ovf_full_rdy: got %b expected 0", wr_rdy_o[0]); end
        write_words(2'b01, 1, 'h7777);
        total++;
        if (err_full_o[0] !== 1'b1) begin bad++; $display("FAIL ovf_err_set: got %b expected 1", err_full_o[0]); end
        repeat (3) clk_step();
        total++;
        if (err_full_o !== 2'b01) begin bad++; $display("FAIL ovf_err_sticky: got %b expected 01", err_full_o); end
        err_clr_i = 1'b1; clk_step(); err_clr_i = 1'b0;
        total++;
        if (err_full_o[0] !== 1'b0) begin bad++; $display("FAIL ovf_err_clr: got %b expected 0", err_full_o[0]); end
        wr_vld_i = 2'b01; err_clr_i = 1'b1; clk_step(); clear_inputs();
        total++;
        if (err_full_o[0] !== 1'b1) begin bad++; $display("FAIL ovf_clr_coincident: got %b expected 1", err_full_o[0]); end
        err_clr_i = 1'b1; clk_step(); err_clr_i = 1'b0;
        total++;
        if (err_full_o[0] !== 1'b0) begin bad++; $display("FAIL ovf_err_clr2: got %b expected 0", err_full_o[0]); end
        run_bursts(DEPTH / BL, 0, 100, 2'b00, 1500);
        total++;
        if (log_ch.size() != DEPTH / BL) begin
            bad++; $display("FAIL ovf_drain: got %0d bursts expected %0d", log_ch.size(), DEPTH / BL);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        write_words(2'b01, 16, 'h4000);
        run_bursts(3, int'($urandom_range(3, 0)), 50, 2'b01, 2000);
        for (int i = 0; i < 3 && i < log_len.size(); i++) begin
            total++;
            if (log_len[i] != 16 || log_ch[i] != 0) begin
                bad++; $display("FAIL b2b_burst[%0d]: got ch=%0d len=%0d expected ch=0 len=16", i, log_ch[i], log_len[i]);
            end
        end
        drain_all(2000);
        total++;
        if (level_o !== '0) begin bad++; $display("FAIL b2b_level: got %0h expected 0", level_o); end
    endtask

    task automatic test_reset_mid_xfer();
        int k;
        apply_reset();
        rd_rdy_i = 1'b1;
        write_words(2'b01, 16, 'h5000);
        k = 0;
        while (!(m_act && m_rem < 12) && k < 100) begin
            burst_gnt_i = burst_req_o;
            clk_step();
            k++;
        end
        burst_gnt_i = 1'b0;
        total++;
        if (!(m_act && m_rem < 12)) begin bad++; $display("FAIL midrst_setup: got idle expected mid-transfer"); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (burst_req_o !== 1'b0) begin bad++; $display("FAIL midrst_req: got %b expected 0", burst_req_o); end
        total++; if (rd_vld_o !== 1'b0)    begin bad++; $display("FAIL midrst_rd_vld: got %b expected 0", rd_vld_o); end
        total++; if (rd_last_o !== 1'b0)   begin bad++; $display("FAIL midrst_rd_last: got %b expected 0", rd_last_o); end
        total++; if (level_o !== '0)       begin bad++; $display("FAIL midrst_level: got %0h expected 0", level_o); end
        total++; if (wr_rdy_o !== '1)      begin bad++; $display("FAIL midrst_wr_rdy: got %b expected 11", wr_rdy_o); end
        total++; if (burst_len_o !== '0)   begin bad++; $display("FAIL midrst_len: got %0d expected 0", burst_len_o); end
        model_reset();
        log_ch.delete();
        log_len.delete();
        @(negedge clk);
        rst_n = 1'b1;
        write_words(2'b01, 3, 'h6000);
        pulse_flush(2'b01);
        run_bursts(1, 1, 100, 2'b00, 100);
        total++;
        if (log_ch.size() != 1 || log_ch[0] != 0 || log_len[0] != 3) begin
            bad++; $display("FAIL midrst_after: got %0d bursts expected 1 burst ch=0 len=3", log_ch.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        rd_rdy_i  = 1'b0;
        wr_data_i = '0;
        last_data = '0;
        clear_inputs();
        model_reset();
        test_reset();
        test_single_burst();
        test_two_channel_rr();
        test_flush();
        test_overflow();
        test_back_to_back();
        test_reset_mid_xfer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
